// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic controllers.
package serial_arith_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int count_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_faob.sv
// One-bit full-adder cell, purely combinational.
module FAOB (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Q,
    output logic Cout
);

    assign Q    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands go LSB-first through one FAOB cell,
// the carry rides in a flop, and the parallel result is posted with a DONE pulse.
//
// state   | meaning
// ST_IDLE | waiting for START; result registers hold the last sum
// ST_RUN  | one operand bit per clock through the full-adder cell
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_InHigh,
    input  logic             START_In,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
    input  logic             CIN_In,
    output logic             BUSY_Out,
    output logic             DONE_Out,
    output logic [WIDTH-1:0] SUM_Out,
    output logic             COUT_Out
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only the upper WIDTH-1 sum bits need storing; the newest bit comes from the cell.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic             fa_q;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_nxt;

    FAOB u_faob (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Q    (fa_q),
        .Cout (fa_cout)
    );

    assign sum_nxt = {fa_q, s_sh_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START_In) begin
                    a_sh_d  = A_In;
                    b_sh_d  = B_In;
                    carry_d = CIN_In;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = sum_nxt[WIDTH-1:1];
                carry_d = fa_cout;
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    sum_d   = sum_nxt;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign BUSY_Out = (state_q == ST_RUN);
    assign DONE_Out = done_q;
    assign SUM_Out  = sum_q;
    assign COUT_Out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in, b_in;
    logic       cin_in;
    logic       busy, done, cout;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst),
        .START_In     (start),
        .A_In         (a_in),
        .B_In         (b_in),
        .CIN_In       (cin_in),
        .BUSY_Out     (busy),
        .DONE_Out     (done),
        .SUM_Out      (sum),
        .COUT_Out     (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (prev_done) check("done_one_cycle", {31'd0, done}, 32'd0);
        prev_done = done;
    end

    // Launch one op and watch 14 cycles. Inputs are scrambled after capture;
    // poke>0 re-pulses START mid-run, rst_at>0 resets mid-run.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c_in,
                          input int poke, input int rst_at,
                          output int done_cyc, output int n_busy, output int n_done,
                          output logic [7:0] s, output logic c);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin_in = c_in;
        done_cyc = 0; n_busy = 0; n_done = 0; s = 8'h00; c = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = i;
                s = sum;
                c = cout;
            end
            if (rst_at != 0 && i == rst_at + 1) begin
                check("rst_mid_busy", {31'd0, busy}, 32'd0);
                check("rst_mid_sum",  {24'd0, sum},  32'd0);
                check("rst_mid_cout", {31'd0, cout}, 32'd0);
                rst = 1'b0;
            end
            if (i == 1) begin
                start = 1'b0; a_in = ~a; b_in = ~b; cin_in = ~c_in;
            end
            if (i == poke) begin
                start = 1'b1; a_in = 8'h10;
            end
            if (poke != 0 && i == poke + 1) start = 1'b0;
            if (i == rst_at) rst = 1'b1;
        end
    endtask

    int         dc, nb, nd;
    logic [7:0] s;
    logic       c;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp9;
    int         bb_n;
    int         bb_cyc [2];
    logic [8:0] bb_res [2];

    initial begin
        rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {24'd0, sum},  32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;

        run_op(8'h5A, 8'h33, 1'b0, 0, 0, dc, nb, nd, s, c);
        check("t1_latency", dc, 9);
        check("t1_busy",    nb, 8);
        check("t1_ndone",   nd, 1);
        check("t1_sum",     {24'd0, s}, 32'h8D);
        check("t1_cout",    {31'd0, c}, 32'd0);
        check("t1_hold",    {23'd0, cout, sum}, 32'h08D);

        run_op(8'hFF, 8'h01, 1'b0, 0, 0, dc, nb, nd, s, c);
        check("t2a_res", {23'd0, c, s}, 32'h100);
        check("t2a_ndone", nd, 1);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 0, dc, nb, nd, s, c);
        check("t2b_res", {23'd0, c, s}, 32'h1FF);

        run_op(8'h00, 8'h00, 1'b1, 3, 0, dc, nb, nd, s, c);
        check("t3_res",     {23'd0, c, s}, 32'h001);
        check("t3_ndone",   nd, 1);
        check("t3_latency", dc, 9);

        run_op(8'h12, 8'h34, 1'b0, 0, 4, dc, nb, nd, s, c);
        check("t4_ndone", nd, 0);
        check("t4_busy",  nb, 4);
        check("t4_sum",   {23'd0, cout, sum}, 32'h000);

        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
        bb_n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (bb_n < 2) begin
                    bb_cyc[bb_n] = i;
                    bb_res[bb_n] = {cout, sum};
                end
                bb_n++;
            end
            if (i == 1) begin a_in = 8'h80; b_in = 8'h80; end
            if (i == 10) start = 1'b0;
        end
        check("t5_ndone", bb_n, 2);
        check("t5_cyc0",  bb_cyc[0], 9);
        check("t5_cyc1",  bb_cyc[1], 18);
        check("t5_res0",  {23'd0, bb_res[0]}, 32'h002);
        check("t5_res1",  {23'd0, bb_res[1]}, 32'h100);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, 0, 0, dc, nb, nd, s, c);
            check("rnd_res",   {23'd0, c, s}, {23'd0, exp9});
            check("rnd_ndone", nd, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
